// File: rtl/iob_wb2iob_bridge_pkg.sv
// Shared definitions for the registered Wishbone-to-IOb bridge family.
package iob_wb2iob_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/iob_wb2iob_bridge_if.sv
// Wishbone-slave plus IOb-master signal bundle; "slave" is the bridge's view.
interface iob_wb2iob_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   wb_addr_i;
   logic [DATA_W/8-1:0] wb_select_i;
   logic                wb_we_i;
   logic                wb_cyc_i;
   logic                wb_stb_i;
   logic [DATA_W-1:0]   wb_data_i;
   logic                wb_ack_o;
   logic                wb_error_o;
   logic [DATA_W-1:0]   wb_data_o;

   logic                valid_o;
   logic [ADDR_W-1:0]   address_o;
   logic [DATA_W-1:0]   wdata_o;
   logic [DATA_W/8-1:0] wstrb_o;
   logic [DATA_W-1:0]   rdata_i;
   logic                ready_i;

   modport slave (
      input  wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
      output wb_ack_o, wb_error_o, wb_data_o,
      output valid_o, address_o, wdata_o, wstrb_o,
      input  rdata_i, ready_i
   );

   modport master (
      output wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
      input  wb_ack_o, wb_error_o, wb_data_o,
      input  valid_o, address_o, wdata_o, wstrb_o,
      output rdata_i, ready_i
   );
endinterface

// File: rtl/iob_timeout_cnt.sv
// Clearable, enabled, saturating up-counter with a terminal-count flag.
module iob_timeout_cnt #(
   parameter int unsigned W  = 8,
   parameter int unsigned TC = 254
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == W'(TC));

endmodule

// File: rtl/iob_wb2iob_bridge.sv
// Registered Wishbone-slave to IOb-master bridge with timeout and cycle-abort handling.
module iob_wb2iob_bridge
   import iob_wb2iob_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TIMEOUT_W = 8,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
   input logic                 clk_i,
   input logic                 arst_i,
   iob_wb2iob_bridge_if.slave  bus
);

   localparam int unsigned STRB_W     = DATA_W / 8;
   localparam int unsigned TC         = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

   state_e              state_q, state_d;
   logic                valid_q, valid_d;
   logic [ADDR_W-1:0]   address_q, address_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic                ack_q, ack_d;
   logic                error_q, error_d;
   logic                abort_q, abort_d;

   logic                cnt_clr, cnt_en, cnt_tc;

   iob_timeout_cnt #(
      .W  (TIMEOUT_W),
      .TC (TC)
   ) u_timeout_cnt (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .tc_o   (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      address_d = address_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wb_data_d = wb_data_q;
      ack_d     = 1'b0;
      error_d   = 1'b0;
      abort_d   = abort_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.wb_cyc_i && bus.wb_stb_i) begin
               address_d = bus.wb_addr_i;
               wdata_d   = bus.wb_data_i;
               wstrb_d   = bus.wb_we_i ? bus.wb_select_i : '0;
               valid_d   = 1'b1;
               cnt_clr   = 1'b1;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            cnt_en = 1'b1;
            // ready_i takes priority over a coinciding timeout.
            if (bus.ready_i) begin
               valid_d = 1'b0;
               if (wstrb_q == '0) begin
                  wb_data_d = bus.rdata_i;
               end
               if (abort_q) begin
                  state_d = ST_IDLE;
               end else begin
                  ack_d   = 1'b1;
                  state_d = ST_ACK;
               end
            end else if (TIMEOUT_EN && cnt_tc) begin
               valid_d = 1'b0;
               if (abort_q) begin
                  state_d = ST_IDLE;
               end else begin
                  error_d   = 1'b1;
                  wb_data_d = '0;
                  state_d   = ST_ERR;
               end
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // The IOb request cannot be withdrawn, so a Wishbone abort only suppresses the response.
      if ((state_q == ST_REQ) && !bus.wb_cyc_i) begin
         abort_d = 1'b1;
      end
      if (state_d == ST_IDLE) begin
         abort_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         address_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wb_data_q <= '0;
         ack_q     <= 1'b0;
         error_q   <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         address_q <= address_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wb_data_q <= wb_data_d;
         ack_q     <= ack_d;
         error_q   <= error_d;
         abort_q   <= abort_d;
      end
   end

   assign bus.valid_o    = valid_q;
   assign bus.address_o  = address_q;
   assign bus.wdata_o    = wdata_q;
   assign bus.wstrb_o    = wstrb_q;
   assign bus.wb_data_o  = wb_data_q;
   assign bus.wb_ack_o   = ack_q;
   assign bus.wb_error_o = error_q;

endmodule

// File: tb/tb_iob_wb2iob_bridge.sv
// Scoreboard bench for iob_wb2iob_bridge: one instance with the default timeout, one with TIMEOUT=4.
module tb_iob_wb2iob_bridge;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk_i  = 1'b0;
   logic arst_i = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   exp_t              sb_q[$];
   exp_t              mon_e;
   logic [DATA_W-1:0] model_rdata = '0;

   always #5 clk_i = ~clk_i;

   iob_wb2iob_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus   ();
   iob_wb2iob_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_t ();

   iob_wb2iob_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(8), .TIMEOUT(255)
   ) dut (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .bus    (bus)
   );

   iob_wb2iob_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(8), .TIMEOUT(4)
   ) dut_t (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .bus    (bus_t)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every ack/error on the main instance must match the oldest outstanding expectation.
   always @(negedge clk_i) begin
      if (bus.wb_ack_o || bus.wb_error_o) begin
         check("ack_err_excl", bus.wb_ack_o & bus.wb_error_o, 0);
         if (sb_q.size() == 0) begin
            check("sb_unexpected_resp", sb_q.size(), 1);
         end else begin
            mon_e = sb_q.pop_front();
            check("resp_err", bus.wb_error_o, mon_e.err);
            check("resp_data", bus.wb_data_o, mon_e.data);
         end
      end
   end

   task automatic idle_bus();
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_select_i = '0;
      bus.wb_addr_i = '0; bus.wb_data_i = '0; bus.rdata_i = '0; bus.ready_i = 0;
      bus_t.wb_cyc_i = 0; bus_t.wb_stb_i = 0; bus_t.wb_we_i = 0; bus_t.wb_select_i = '0;
      bus_t.wb_addr_i = '0; bus_t.wb_data_i = '0; bus_t.rdata_i = '0; bus_t.ready_i = 0;
   endtask

   task automatic xfer(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input logic [3:0] sel, input logic we,
                       input logic [DATA_W-1:0] rdata, input int ready_dly);
      exp_t       e;
      logic [3:0] exp_strb;
      exp_strb = we ? sel : 4'b0000;
      if (!we) model_rdata = rdata;
      e.err  = 1'b0;
      e.data = model_rdata;
      sb_q.push_back(e);
      @(posedge clk_i); #1;
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we; bus.wb_select_i = sel;
      bus.wb_addr_i = addr; bus.wb_data_i = wdata;
      @(posedge clk_i); #1;
      for (int i = 0; i <= ready_dly; i++) begin
         if (i == ready_dly) begin
            bus.ready_i = 1; bus.rdata_i = rdata;
         end
         @(negedge clk_i);
         check("req_valid", bus.valid_o, 1);
         check("req_addr", bus.address_o, addr);
         check("req_wdata", bus.wdata_o, wdata);
         check("req_wstrb", bus.wstrb_o, exp_strb);
         @(posedge clk_i); #1;
      end
      bus.ready_i = 0; bus.rdata_i = '1;
      @(negedge clk_i);
      check("ack_valid_low", bus.valid_o, 0);
      @(posedge clk_i); #1;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      check("sb_drain", sb_q.size(), 0);
   endtask

   task automatic b2b_reads(input int n);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_select_i = 4'hF;
      for (int k = 0; k < n; k++) begin
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         exp_t              e;
         a = 32'h0000_0100 + 32'(4 * k);
         d = 32'hA500_0000 + 32'(k * 32'h111);
         bus.wb_addr_i = a;
         @(posedge clk_i); #1;
         bus.ready_i = 1; bus.rdata_i = d;
         model_rdata = d;
         e.err = 1'b0; e.data = d;
         sb_q.push_back(e);
         @(negedge clk_i);
         check("b2b_valid", bus.valid_o, 1);
         check("b2b_addr", bus.address_o, a);
         check("b2b_wstrb", bus.wstrb_o, 0);
         @(posedge clk_i); #1;
         bus.ready_i = 0;
         @(negedge clk_i);
         check("b2b_valid_ack", bus.valid_o, 0);
         @(posedge clk_i); #1;
         @(negedge clk_i);
         check("b2b_valid_idle", bus.valid_o, 0);
      end
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      @(posedge clk_i); #1;
      check("b2b_drain", sb_q.size(), 0);
   endtask

   task automatic abort_write();
      @(posedge clk_i); #1;
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_select_i = 4'hF;
      bus.wb_addr_i = 32'h0000_0030; bus.wb_data_i = 32'h0000_55AA;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("abort_valid1", bus.valid_o, 1);
      @(posedge clk_i); #1;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("abort_hold_valid", bus.valid_o, 1);
         check("abort_hold_wdata", bus.wdata_o, 32'h0000_55AA);
         check("abort_no_resp", bus.wb_ack_o | bus.wb_error_o, 0);
         @(posedge clk_i); #1;
      end
      bus.ready_i = 1; bus.rdata_i = 32'hFFFF_0000;
      @(negedge clk_i);
      check("abort_valid_pre_ready", bus.valid_o, 1);
      @(posedge clk_i); #1;
      bus.ready_i = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         check("abort_done_valid", bus.valid_o, 0);
         check("abort_done_no_resp", bus.wb_ack_o | bus.wb_error_o, 0);
         @(posedge clk_i); #1;
      end
   endtask

   task automatic reset_mid_req();
      @(posedge clk_i); #1;
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_select_i = 4'hC;
      bus.wb_addr_i = 32'h0000_0040; bus.wb_data_i = 32'hCAFE_F00D;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("rst_pre_valid", bus.valid_o, 1);
      #1 arst_i = 1;
      #1;
      check("rst_valid", bus.valid_o, 0);
      check("rst_addr", bus.address_o, 0);
      check("rst_wdata", bus.wdata_o, 0);
      check("rst_wstrb", bus.wstrb_o, 0);
      check("rst_wb_data", bus.wb_data_o, 0);
      check("rst_ack_err", bus.wb_ack_o | bus.wb_error_o, 0);
      idle_bus();
      model_rdata = '0;
      #1 arst_i = 0;
   endtask

   task automatic t_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
      @(posedge clk_i); #1;
      bus_t.wb_cyc_i = 1; bus_t.wb_stb_i = 1; bus_t.wb_we_i = 0; bus_t.wb_addr_i = addr;
      @(posedge clk_i); #1;
      bus_t.ready_i = 1; bus_t.rdata_i = d;
      @(negedge clk_i);
      check("t_valid", bus_t.valid_o, 1);
      check("t_wstrb", bus_t.wstrb_o, 0);
      @(posedge clk_i); #1;
      bus_t.ready_i = 0;
      @(negedge clk_i);
      check("t_ack", bus_t.wb_ack_o, 1);
      check("t_err", bus_t.wb_error_o, 0);
      check("t_data", bus_t.wb_data_o, d);
      @(posedge clk_i); #1;
      bus_t.wb_cyc_i = 0; bus_t.wb_stb_i = 0;
   endtask

   task automatic timeout_case();
      t_read(32'h0000_0050, 32'h0BAD_0BAD);
      @(posedge clk_i); #1;
      bus_t.wb_cyc_i = 1; bus_t.wb_stb_i = 1; bus_t.wb_we_i = 0; bus_t.wb_addr_i = 32'h0000_0054;
      @(posedge clk_i); #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("to_valid", bus_t.valid_o, 1);
         check("to_err_early", bus_t.wb_error_o, 0);
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      check("to_valid_drop", bus_t.valid_o, 0);
      check("to_err", bus_t.wb_error_o, 1);
      check("to_no_ack", bus_t.wb_ack_o, 0);
      check("to_data_zero", bus_t.wb_data_o, 0);
      @(posedge clk_i); #1;
      bus_t.wb_cyc_i = 0; bus_t.wb_stb_i = 0;
      @(negedge clk_i);
      check("to_err_once", bus_t.wb_error_o, 0);
      t_read(32'h0000_0058, 32'h7777_1234);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_bus();
      #1 arst_i = 1;
      #2;
      check("reset_valid", bus.valid_o, 0);
      check("reset_ack", bus.wb_ack_o, 0);
      check("reset_err", bus.wb_error_o, 0);
      check("reset_wb_data", bus.wb_data_o, 0);
      check("reset_wstrb", bus.wstrb_o, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      arst_i = 0;

      xfer(32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 1'b1, 32'h1111_1111, 2);
      xfer(32'h0000_0020, 32'h0000_0000, 4'b1111, 1'b0, 32'h1234_5678, 0);
      b2b_reads(3);
      abort_write();
      xfer(32'h0000_0024, 32'h0000_0000, 4'b1111, 1'b0, 32'h8765_4321, 1);
      reset_mid_req();
      xfer(32'h0000_0044, 32'h0000_0000, 4'b1111, 1'b0, 32'h5A5A_A5A5, 0);
      timeout_case();

      repeat (3) @(posedge clk_i);
      check("final_sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iob_wb2iob_bridge.md
Name: iob_wb2iob_bridge

Overview:
- Registered Wishbone-slave to IOb-master bridge.
- Successor to the combinational Wishbone-to-IOb adapter: registers the request, holds it stable until ready_i, and returns a one-cycle ack or error to Wishbone.
- Adds a configurable timeout and clean handling of Wishbone cycle aborts.
- Sits between a Wishbone master (e.g. MAC DMA) and the IOb system bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- TIMEOUT_W, 8, width of the timeout counter.
- TIMEOUT, 255, REQ cycles without ready_i before an error is raised; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous reset, active-high
- wb_addr_i  in  ADDR_W  Wishbone address
- wb_select_i  in  DATA_W/8  byte selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_data_i  in  DATA_W  write data
- wb_ack_o  out  1  one-cycle acknowledge
- wb_error_o  out  1  one-cycle error (timeout)
- wb_data_o  out  DATA_W  registered read data
- valid_o  out  1  IOb request valid
- address_o  out  ADDR_W  IOb address
- wdata_o  out  DATA_W  IOb write data
- wstrb_o  out  DATA_W/8  IOb write strobes; 0 means read
- rdata_i  in  DATA_W  IOb read data
- ready_i  in  1  IOb ready

Behaviour:
- Reset (arst_i=1, asynchronous): state IDLE; all outputs 0; counter 0; abort flag 0.
- All outputs come straight from registers; there are no combinational paths from input to output.
- States: IDLE, REQ, ACK, ERR.
- IDLE:
  - wb_cyc_i&wb_stb_i sampled high at edge N: capture address, wdata, and wstrb = wb_we_i ? wb_select_i : 0.
  - Go to REQ; valid_o=1 from edge N.
- REQ:
  - valid_o, address_o, wdata_o and wstrb_o stay stable.
  - Counter increments each cycle.
  - ready_i=1: capture rdata_i into wb_data_o (reads only; writes leave wb_data_o unchanged); valid_o=0 next cycle; go to ACK.
  - If the abort flag is set, go to IDLE instead of ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. New requests are not sampled in ACK.
- Timeout:
  - TIMEOUT!=0 and counter==TIMEOUT-1 with ready_i=0 in REQ: valid_o=0, go to ERR.
  - ERR: wb_error_o=1 for one cycle, wb_data_o=0, then IDLE.
  - If ready_i and the timeout coincide, ready_i wins.
- Abort: wb_cyc_i=0 during REQ sets the abort flag.
  - The IOb request cannot be withdrawn, so valid_o is held until ready_i.
  - No ack or error is issued; the flag clears on the return to IDLE.
  - Timeout still applies and goes to IDLE silently when the flag is set.
- ready_i outside REQ is ignored.
- Latency: Wishbone request to valid_o is 1 cycle; ready_i to wb_ack_o is 1 cycle; minimum transaction is 3 cycles.
- Counter clears on entry to REQ and saturates; it never wraps.
- wb_ack_o and wb_error_o are never high together.
- Reset asserted mid-transaction drops valid_o immediately (asynchronous clear) and discards the request.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, REQ=2'd1, ACK=2'd2, ERR=2'd3) and the default TIMEOUT value.
- Optional sub-module iob_timeout_cnt: clear, enable and saturate, with a terminal-count output. It is reusable by other IOb bridges.
- Everything else stays in one module.

Test Plan:
- Write 0x0000_0010 ← 0xDEADBEEF, sel=4'b0011, ready_i asserted 2 cycles after valid_o → wstrb_o=0011 and wdata_o=DEADBEEF held stable; one wb_ack_o pulse; wb_error_o=0.
- Read 0x0000_0020, ready_i in the first REQ cycle with rdata_i=0x12345678 → wstrb_o=0; wb_ack_o next cycle with wb_data_o=0x12345678.
- TIMEOUT=4, ready_i never asserted → valid_o high 4 cycles; wb_error_o pulses once; wb_data_o=0; bridge accepts the next request.
- wb_cyc_i dropped in the second REQ cycle, ready_i 3 cycles later → no ack and no error; valid_o held until ready_i; back to IDLE.
- Back-to-back reads with stb held → one transaction per 3 cycles; each ack matches its own data.
- arst_i pulsed while in REQ → valid_o=0 without waiting for a clock edge; all outputs 0; a later request completes normally.
